// File: rtl/led_pwm_driver_pkg.sv
// Shared types and helpers for the LED pin driver and its period generator.
package LED_Pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } breath_state_e;

    // A counter of N states needs clog2(N) bits; keep at least one bit for N = 1.
    function automatic int unsigned period_cnt_width(input int unsigned periods);
        return (periods <= 1) ? 1 : $clog2(periods);
    endfunction

endpackage

// File: rtl/led_pwm_driver_pwm_period_gen.sv
// Free-running PWM period counter: 0 .. 2^PWM_BITS-2, with a boundary strobe and a registered sync pulse.
module pwm_period_gen #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                lb_clk,
    input  logic                rst,
    output logic [PWM_BITS-1:0] cnt,
    output logic                period_start,
    output logic                pwm_sync
);

    // Stopping one short of all-ones lets a duty of all-ones mean "always on".
    localparam logic [PWM_BITS-1:0] CNT_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};

    assign period_start = (cnt == '0);

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            cnt      <= '0;
            pwm_sync <= 1'b0;
        end else begin
            cnt      <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            pwm_sync <= period_start;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// Drives active-low LED pads from the latched LED pattern with global PWM dimming,
// optional triangle breathing and per-LED blink.
module led_pwm_driver
    import LED_Pkg::*;
#(
    parameter int unsigned LED_NUM        = 8,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned BLINK_PERIODS  = 4096,
    parameter int unsigned BREATH_PERIODS = 16
) (
    input  logic                lb_clk,
    input  logic                rst,
    input  logic [LED_NUM-1:0]  led_in,
    input  logic [LED_NUM-1:0]  blink_mask,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                breathe_en,
    output logic [LED_NUM-1:0]  led_out,
    output logic                pwm_sync
);

    localparam int unsigned BLINK_W  = period_cnt_width(BLINK_PERIODS);
    localparam int unsigned BREATH_W = period_cnt_width(BREATH_PERIODS);
    localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_PERIODS - 1);
    localparam logic [BREATH_W-1:0] BREATH_LAST = BREATH_W'(BREATH_PERIODS - 1);

    logic [PWM_BITS-1:0] cnt;
    logic                period_start;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] ramp, ramp_eff, ramp_next;
    breath_state_e       state, state_eff, state_next;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    logic [BREATH_W-1:0] breath_cnt;
    logic                step_due;
    logic                pwm_on;
    logic [LED_NUM-1:0]  lit;

    pwm_period_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_period_gen (
        .lb_clk       (lb_clk),
        .rst          (rst),
        .cnt          (cnt),
        .period_start (period_start),
        .pwm_sync     (pwm_sync)
    );

    assign step_due = breathe_en & period_start & (breath_cnt == BREATH_LAST);

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            ramp  <= '0;
            state <= UP;
        end else begin
            ramp  <= ramp_next;
            state <= state_next;
        end
    end

    // Clamp is applied combinationally so a lowered target is seen by the duty load in the same cycle.
    always_comb begin
        ramp_eff   = ramp;
        state_eff  = state;
        ramp_next  = '0;
        state_next = UP;
        if (ramp > brightness) begin
            ramp_eff  = brightness;
            state_eff = DOWN;
        end
        if (breathe_en) begin
            ramp_next  = ramp_eff;
            state_next = state_eff;
            if (step_due) begin
                if (state_eff == UP && ramp_eff < brightness) begin
                    ramp_next = ramp_eff + 1'b1;
                end else if (state_eff == DOWN && ramp_eff != '0) begin
                    ramp_next = ramp_eff - 1'b1;
                end
                if (ramp_next == brightness) begin
                    state_next = DOWN;
                end else if (ramp_next == '0) begin
                    state_next = UP;
                end
            end
        end
    end

    assign pwm_on = (cnt < duty);
    assign lit    = ~led_in & {LED_NUM{pwm_on}} & (~blink_mask | {LED_NUM{blink_phase}});

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            duty        <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            breath_cnt  <= '0;
            led_out     <= '1;
        end else begin
            led_out <= ~lit;
            if (period_start) begin
                duty <= breathe_en ? ramp_eff : brightness;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            if (!breathe_en) begin
                breath_cnt <= '0;
            end else if (period_start) begin
                breath_cnt <= (breath_cnt == BREATH_LAST) ? '0 : breath_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Randomised bench for led_pwm_driver against a cycle-level behavioural model.
module tb_led_pwm_driver;

    localparam int LED_NUM = 8;
    localparam int PWM_BITS = 4;
    localparam int BLINK = 2;
    localparam int BREATH = 1;
    localparam int PERIOD = 15;

    logic       lb_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] led_in = 8'h00;
    logic [7:0] blink_mask = 8'h00;
    logic [3:0] brightness = 4'd15;
    logic       breathe_en = 1'b0;
    logic [7:0] led_out;
    logic       pwm_sync;

    int n_checks = 0;
    int n_fail = 0;

    int m_cnt, m_duty, m_ramp, m_bounds, m_en_bounds;
    bit m_rising;
    logic [7:0] exp_led;
    logic exp_sync;

    led_pwm_driver #(
        .LED_NUM        (LED_NUM),
        .PWM_BITS       (PWM_BITS),
        .BLINK_PERIODS  (BLINK),
        .BREATH_PERIODS (BREATH)
    ) dut (
        .lb_clk     (lb_clk),
        .rst        (rst),
        .led_in     (led_in),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .breathe_en (breathe_en),
        .led_out    (led_out),
        .pwm_sync   (pwm_sync)
    );

    always #5 lb_clk = ~lb_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock of the reference behaviour, using the inputs the DUT sampled at this edge.
    task automatic model_step();
        logic [7:0] lit;
        bit on, phase;
        int b;
        b = int'(brightness);
        if (rst) begin
            exp_led = 8'hFF; exp_sync = 1'b0;
            m_cnt = 0; m_duty = 0; m_ramp = 0; m_rising = 1'b1;
            m_bounds = 0; m_en_bounds = 0;
        end else begin
            on    = (m_cnt < m_duty);
            phase = ((m_bounds / BLINK) % 2) == 0;
            lit = ~led_in & (on ? 8'hFF : 8'h00) & (~blink_mask | (phase ? 8'hFF : 8'h00));
            exp_led  = ~lit;
            exp_sync = (m_cnt == 0);
            if (!breathe_en) begin
                m_ramp = 0; m_rising = 1'b1; m_en_bounds = 0;
            end else if (m_ramp > b) begin
                m_ramp = b; m_rising = 1'b0;
            end
            if (m_cnt == 0) begin
                m_bounds++;
                if (breathe_en) begin
                    m_duty = m_ramp;
                    m_en_bounds++;
                    if (m_en_bounds % BREATH == 0) begin
                        if (m_rising && m_ramp < b) m_ramp++;
                        else if (!m_rising && m_ramp > 0) m_ramp--;
                        if (m_ramp == b) m_rising = 1'b0;
                        else if (m_ramp == 0) m_rising = 1'b1;
                    end
                end else begin
                    m_duty = b;
                end
            end
            m_cnt = (m_cnt + 1) % PERIOD;
        end
    endtask

    task automatic run_cycle();
        @(posedge lb_clk);
        model_step();
        #1;
        check_val("led_out", 32'(led_out), 32'(exp_led));
        check_val("pwm_sync", 32'(pwm_sync), 32'(exp_sync));
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        int lows;
        bit found;

        // Reset with full brightness, all LEDs on.
        rst = 1'b1; brightness = 4'd15; led_in = 8'h00; blink_mask = 8'h00; breathe_en = 1'b0;
        run_n(3);
        rst = 1'b0;
        run_n(40);

        // Fixed duty of 5 on LED 0.
        brightness = 4'd5; led_in = 8'hFE;
        run_n(35);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pwm_sync) found = 1'b1;
            else run_cycle();
        end
        check_val("sync_found", 32'(found), 32'd1);
        lows = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (!led_out[0]) lows++;
            if (led_out[7:1] !== 7'h7F) check_val("dark_bits", 32'(led_out[7:1]), 32'h7F);
            if (i < PERIOD - 1) run_cycle();
        end
        check_val("duty5_lows", 32'(lows), 32'd5);

        // Brightness change mid-period.
        run_n(6);
        brightness = 4'd10;
        run_n(35);

        // Blink on LED 0.
        blink_mask = 8'h01; brightness = 4'd15; led_in = 8'h00;
        run_n(130);

        // Breathing to 3, then lower the target while the ramp sits at 3.
        blink_mask = 8'h00; led_in = 8'hFE; brightness = 4'd3; breathe_en = 1'b1;
        run_n(8 * PERIOD);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_ramp == 3 && m_cnt == 5) found = 1'b1;
            else run_cycle();
        end
        check_val("ramp_at_3", 32'(found), 32'd1);
        brightness = 4'd1;
        run_n(4 * PERIOD);

        // Mid-run reset while blinking and breathing, then replay the reset scenario.
        blink_mask = 8'h0F; brightness = 4'd9; led_in = 8'h00;
        run_n(47);
        rst = 1'b1;
        run_cycle();
        check_val("midrst_led", 32'(led_out), 32'hFF);
        check_val("midrst_sync", 32'(pwm_sync), 32'd0);
        rst = 1'b1; brightness = 4'd15; led_in = 8'h00; blink_mask = 8'h00; breathe_en = 1'b0;
        run_n(2);
        rst = 1'b0;
        run_n(40);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0) led_in = 8'($urandom);
            if ($urandom_range(0, 15) == 0) blink_mask = 8'($urandom);
            if ($urandom_range(0, 39) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) breathe_en = ~breathe_en;
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
